// File: rtl/half_dot_row_sched.sv
// half_dot_row_sched
//   Sequences one matrix-vector pass over a shared half-precision dot-product
//   engine: for each row r in 0..HEIGHT-1 it pulses dot_start with row_idx=r,
//   waits for dot_done and latches dot_c into vector_out[r]. done pulses once
//   after the last row.
//
//   Optional feature macro: HALF_DOT_SCHED_TIMEOUT_EN
//     defined   -> per-row watchdog of TIMEOUT cycles in WAIT; on expiry the
//                  sticky timeout flag is set and the pass ends via DONE.
//     undefined -> no watchdog, timeout tied low.
//
// Ports
//   clk        : sole clock, rising edge
//   rst        : synchronous active-high reset
//   start      : begin a pass (accepted in IDLE only)
//   abort      : cancel an in-progress pass
//   busy       : high outside IDLE
//   done       : one-cycle pass-complete pulse
//   row_idx    : row selected for the engine's vector_b mux
//   dot_start  : one-cycle engine start pulse
//   dot_done   : engine completion pulse
//   dot_c      : engine result (IEEE half), valid with dot_done
//   vector_out : collected results, element r from row r
//   timeout    : sticky watchdog error flag

module half_dot_row_sched #(
    parameter int HEIGHT  = 10,
    parameter int TIMEOUT = 1024
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          start,
    input  logic                                          abort,
    output logic                                          busy,
    output logic                                          done,
    output logic [((HEIGHT > 1) ? $clog2(HEIGHT) : 1)-1:0] row_idx,
    output logic                                          dot_start,
    input  logic                                          dot_done,
    input  logic [15:0]                                   dot_c,
    output logic [15:0]                                   vector_out [HEIGHT],
    output logic                                          timeout
);

    localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic last_row;
    logic accept;
    logic result_wr;
    logic wd_expire;

    assign last_row  = (row_idx == RW'(HEIGHT - 1));
    // abort outranks start in IDLE
    assign accept    = (state == S_IDLE) && start && !abort;
    // abort outranks a coincident dot_done: the result is dropped
    assign result_wr = (state == S_WAIT) && dot_done && !abort;

`ifdef HALF_DOT_SCHED_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT);

    logic [CW-1:0] wait_cnt;

    // Held at zero outside WAIT, so it starts from zero on every WAIT entry.
    always_ff @(posedge clk) begin
        if (rst || state != S_WAIT) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // Fires in the TIMEOUT-th WAIT cycle that has no dot_done.
    assign wd_expire = (state == S_WAIT) && !dot_done && !abort &&
                       (wait_cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst || accept) begin
            timeout <= 1'b0;
        end else if (wd_expire) begin
            timeout <= 1'b1;
        end
    end
`else
    // TIMEOUT only matters when the watchdog is built in.
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT > 1);
    assign wd_expire          = 1'b0;
    assign timeout            = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE: begin
                if (accept) begin
                    state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_next = abort ? S_IDLE : S_WAIT;
            end
            S_WAIT: begin
                if (abort) begin
                    state_next = S_IDLE;
                end else if (dot_done) begin
                    state_next = last_row ? S_DONE : S_ISSUE;
                end else if (wd_expire) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Outputs. dot_start and done are masked by abort so a cancelled pass
    // never launches the engine or reports completion.
    always_comb begin
        busy      = (state != S_IDLE);
        dot_start = (state == S_ISSUE) && !abort;
        done      = (state == S_DONE) && !abort;
    end

    // Row pointer: advances only on an accepted result for a non-final row.
    always_ff @(posedge clk) begin
        if (rst) begin
            row_idx <= '0;
        end else if (abort || state == S_IDLE || state == S_DONE) begin
            row_idx <= '0;
        end else if (result_wr && !last_row) begin
            row_idx <= row_idx + 1'b1;
        end
    end

    // Result storage: plain register copies of dot_c.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < HEIGHT; i++) begin
                vector_out[i] <= '0;
            end
        end else if (result_wr) begin
            vector_out[row_idx] <= dot_c;
        end
    end

endmodule

// File: tb/tb_half_dot_row_sched.sv
// Directed bench for half_dot_row_sched with HEIGHT=3 and an engine latency
// of 4 cycles emulated by the stimulus sequence.

module tb_half_dot_row_sched;

    localparam int H = 3;
    localparam int L = 4;
`ifdef HALF_DOT_SCHED_TIMEOUT_EN
    localparam int TO = 8;
`else
    localparam int TO = 1024;
`endif

    logic        clk;
    logic        rst;
    logic        start;
    logic        abort;
    logic        busy;
    logic        done;
    logic [1:0]  row_idx;
    logic        dot_start;
    logic        dot_done;
    logic [15:0] dot_c;
    logic [15:0] vector_out [H];
    logic        timeout;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int t0;

    half_dot_row_sched #(
        .HEIGHT  (H),
        .TIMEOUT (TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .row_idx    (row_idx),
        .dot_start  (dot_start),
        .dot_done   (dot_done),
        .dot_c      (dot_c),
        .vector_out (vector_out),
        .timeout    (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
            $error("%s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_vec(input string tag, input logic [15:0] e0,
                             input logic [15:0] e1, input logic [15:0] e2);
        check({tag, "_v0"}, {16'h0, vector_out[0]}, {16'h0, e0});
        check({tag, "_v1"}, {16'h0, vector_out[1]}, {16'h0, e1});
        check({tag, "_v2"}, {16'h0, vector_out[2]}, {16'h0, e2});
    endtask

    // Called while the DUT is in ISSUE for row r; returns after the edge that
    // consumes the engine result (DUT then in ISSUE of r+1 or DONE).
    task automatic do_row(input int r, input logic [15:0] val);
        check("issue_start", {31'b0, dot_start}, 32'd1);
        check("issue_row", {30'b0, row_idx}, r);
        for (int i = 0; i < L; i++) begin
            tick();
            check("wait_nostart", {31'b0, dot_start}, 32'd0);
            check("wait_row", {30'b0, row_idx}, r);
            check("wait_nodone", {31'b0, done}, 32'd0);
        end
        dot_done = 1'b1;
        dot_c    = val;
        tick();
        dot_done = 1'b0;
        dot_c    = 16'hDEAD;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; dot_done = 1'b0; dot_c = 16'h0;

        // Reset state
        tick(); tick();
        rst = 1'b0;
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_dot_start", {31'b0, dot_start}, 32'd0);
        check("rst_row", {30'b0, row_idx}, 32'd0);
        check("rst_timeout", {31'b0, timeout}, 32'd0);
        check_vec("rst", 16'h0000, 16'h0000, 16'h0000);
        tick();
        check("idle_busy", {31'b0, busy}, 32'd0);

        // Basic pass: 3 rows, latency 4, done 15 edges after the start edge
        start = 1'b1;
        tick();
        t0 = cyc;
        start = 1'b0;
        check("p1_busy", {31'b0, busy}, 32'd1);
        do_row(0, 16'h3C00);
        do_row(1, 16'h4000);
        do_row(2, 16'h4200);
        check("p1_done", {31'b0, done}, 32'd1);
        check("p1_latency", cyc - t0, 32'd15);
        check("p1_dot_start_in_done", {31'b0, dot_start}, 32'd0);
        check_vec("p1", 16'h3C00, 16'h4000, 16'h4200);
        tick();
        check("p1_done_once", {31'b0, done}, 32'd0);
        check("p1_idle", {31'b0, busy}, 32'd0);

        // start held high: next pass only after passing through IDLE
        start = 1'b1;
        tick();
        do_row(0, 16'h5555);
        do_row(1, 16'hAAAA);
        do_row(2, 16'h7C00);
        check("p2_done", {31'b0, done}, 32'd1);
        tick();
        check("p2_idle_busy", {31'b0, busy}, 32'd0);
        check("p2_idle_dot_start", {31'b0, dot_start}, 32'd0);
        tick();
        check("p2_restart", {31'b0, dot_start}, 32'd1);
        check("p2_restart_row", {30'b0, row_idx}, 32'd0);
        start = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("p2_abort_issue", {31'b0, busy}, 32'd0);
        check_vec("p2", 16'h5555, 16'hAAAA, 16'h7C00);

        // abort coincident with the second dot_done
        start = 1'b1;
        tick();
        start = 1'b0;
        do_row(0, 16'h3C00);
        check("p3_issue1", {31'b0, dot_start}, 32'd1);
        for (int i = 0; i < L; i++) tick();
        dot_done = 1'b1; dot_c = 16'h1234; abort = 1'b1;
        check("p3_abort_nodone", {31'b0, done}, 32'd0);
        tick();
        dot_done = 1'b0; abort = 1'b0;
        check("p3_busy", {31'b0, busy}, 32'd0);
        check("p3_row", {30'b0, row_idx}, 32'd0);
        check("p3_done", {31'b0, done}, 32'd0);
        check_vec("p3", 16'h3C00, 16'hAAAA, 16'h7C00);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("p3_quiet_done", {31'b0, done}, 32'd0);
            check("p3_quiet_busy", {31'b0, busy}, 32'd0);
        end

        // spurious dot_done in IDLE and ISSUE
        dot_done = 1'b1; dot_c = 16'hFFFF;
        tick();
        check("sp_idle_busy", {31'b0, busy}, 32'd0);
        check_vec("sp_idle", 16'h3C00, 16'hAAAA, 16'h7C00);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("sp_issue", {31'b0, dot_start}, 32'd1);
        tick();
        dot_done = 1'b0;
        check("sp_wait_busy", {31'b0, busy}, 32'd1);
        check("sp_wait_nostart", {31'b0, dot_start}, 32'd0);
        check("sp_wait_row", {30'b0, row_idx}, 32'd0);
        check_vec("sp_issue", 16'h3C00, 16'hAAAA, 16'h7C00);
        tick(); tick(); tick();
        dot_done = 1'b1; dot_c = 16'h4000;
        tick();
        dot_done = 1'b0;
        check("sp_row1_start", {31'b0, dot_start}, 32'd1);
        check("sp_row1", {30'b0, row_idx}, 32'd1);
        check("sp_v0", {16'h0, vector_out[0]}, 32'h4000);

        // reset in WAIT of row 1, overriding start
        tick();
        rst = 1'b1; start = 1'b1;
        tick();
        check("mrst_busy", {31'b0, busy}, 32'd0);
        check("mrst_dot_start", {31'b0, dot_start}, 32'd0);
        check("mrst_row", {30'b0, row_idx}, 32'd0);
        check("mrst_done", {31'b0, done}, 32'd0);
        check("mrst_timeout", {31'b0, timeout}, 32'd0);
        check_vec("mrst", 16'h0000, 16'h0000, 16'h0000);
        rst = 1'b0; start = 1'b0;
        tick();
        check("mrst_idle", {31'b0, busy}, 32'd0);

`ifdef HALF_DOT_SCHED_TIMEOUT_EN
        // watchdog: engine never answers row 0
        start = 1'b1;
        tick();
        start = 1'b0;
        check("to_issue", {31'b0, dot_start}, 32'd1);
        for (int i = 0; i < TO; i++) begin
            tick();
            check("to_wait_flag", {31'b0, timeout}, 32'd0);
            check("to_wait_busy", {31'b0, busy}, 32'd1);
            check("to_wait_done", {31'b0, done}, 32'd0);
        end
        tick();
        check("to_done", {31'b0, done}, 32'd1);
        check("to_flag", {31'b0, timeout}, 32'd1);
        check("to_v0", {16'h0, vector_out[0]}, 32'h0000);
        tick();
        check("to_idle", {31'b0, busy}, 32'd0);
        check("to_sticky", {31'b0, timeout}, 32'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("to_clear", {31'b0, timeout}, 32'd0);
        check("to_restart", {31'b0, dot_start}, 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("to_abort", {31'b0, busy}, 32'd0);
`else
        // no watchdog: WAIT holds indefinitely, timeout stays low
        start = 1'b1;
        tick();
        start = 1'b0;
        check("st_issue", {31'b0, dot_start}, 32'd1);
        for (int i = 0; i < 40; i++) begin
            tick();
            check("st_wait_busy", {31'b0, busy}, 32'd1);
            check("st_wait_done", {31'b0, done}, 32'd0);
            check("st_timeout", {31'b0, timeout}, 32'd0);
        end
        dot_done = 1'b1; dot_c = 16'hC000;
        tick();
        dot_done = 1'b0;
        check("st_row1", {30'b0, row_idx}, 32'd1);
        check("st_v0", {16'h0, vector_out[0]}, 32'hC000);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("st_abort", {31'b0, busy}, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/half_dot_row_sched.md
HALF_DOT_ROW_SCHED -- requirements
Module: half_dot_row_sched

Interface
REQ-001 Parameter: HEIGHT, default 10, number of matrix rows (output elements) sequenced; legal range 1..1024.
REQ-002 Parameter: TIMEOUT, default 1024, max cycles waited for dot_done per row; legal range 2..65535.
REQ-003 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  synchronous, active-high reset.
REQ-005 Port: start  input  1  request one full matrix-vector pass; sampled only in IDLE.
REQ-006 Port: abort  input  1  cancel an in-progress pass.
REQ-007 Port: busy  output  1  high in every state except IDLE.
REQ-008 Port: done  output  1  one-cycle pulse at pass completion.
REQ-009 Port: row_idx  output  max(1,$clog2(HEIGHT))  row currently selected for the shared dot-product engine's vector_b mux.
REQ-010 Port: dot_start  output  1  one-cycle start pulse to the shared half_dot_v_v engine.
REQ-011 Port: dot_done  input  1  engine completion pulse.
REQ-012 Port: dot_c  input  16  engine result, IEEE half precision, valid while dot_done is high.
REQ-013 Port: vector_out  output  16 x HEIGHT (unpacked array [HEIGHT])  collected results, element r from row r.
REQ-014 Port: timeout  output  1  sticky error flag (see Configuration).

Function
REQ-015 FSM states SHALL be IDLE, ISSUE, WAIT, DONE; encoding is free.
REQ-016 IDLE: start=1 -> ISSUE with row_idx=0; start=0 -> stay.
REQ-017 ISSUE: dot_start=1 for exactly this cycle, then -> WAIT; row_idx held stable from ISSUE through WAIT.
REQ-018 WAIT: dot_done=1 -> vector_out[row_idx] <= dot_c in that cycle; if row_idx==HEIGHT-1 -> DONE, else row_idx+1 and -> ISSUE.
REQ-019 DONE: done=1 for this single cycle, then -> IDLE; row_idx returns to 0.
REQ-020 dot_done outside WAIT SHALL be ignored; no vector_out write.
REQ-021 start while busy=1 SHALL be ignored, not queued; start in the same cycle that DONE is exited SHALL not be accepted (accepted from IDLE only).
REQ-022 abort=1 in ISSUE/WAIT/DONE -> IDLE next cycle, no done pulse, row_idx=0, already-written vector_out elements retained; abort has priority over dot_done in the same cycle (no write).
REQ-023 abort in IDLE has no effect and takes priority over start (pass not begun).
REQ-024 vector_out elements SHALL be pure register copies of dot_c; no arithmetic, no rounding; unwritten elements keep prior values across passes.
REQ-025 Pass latency with engine latency L per row: HEIGHT*(1+L)+1 cycles from start sample to done pulse; HEIGHT=1 degenerates to ISSUE, WAIT, DONE only.

Reset
REQ-026 rst=1 at any clock edge, including mid-pass, SHALL force IDLE, busy=0, done=0, dot_start=0, row_idx=0, timeout=0, every vector_out element 16'h0000; rst overrides start, abort, dot_done.

Configuration
REQ-027 Macro HALF_DOT_SCHED_TIMEOUT_EN defined: a cycle counter clears on entering WAIT; if TIMEOUT cycles elapse in WAIT without dot_done, timeout<=1, vector_out[row_idx] unwritten, FSM -> DONE (done pulses), remaining rows skipped.
REQ-028 With the macro defined, timeout SHALL stay high until rst or the next accepted start.
REQ-029 Macro undefined: no counter logic; timeout port SHALL be tied 0; WAIT lasts indefinitely until dot_done, abort or rst.

Verification
REQ-030 HEIGHT=3, engine L=4, start pulse, dot_c=16'h3C00/16'h4000/16'h4200 per row -> vector_out={3C00,4000,4200}, three dot_start pulses with row_idx 0,1,2, done 1 cycle at cycle 16.
REQ-031 start held high 40 cycles, HEIGHT=3 -> second pass begins only after return to IDLE; no dot_start while row_idx mid-pass re-zeroed.
REQ-032 abort coincident with second dot_done -> no done, vector_out[0]=3C00, vector_out[1] unchanged, IDLE next cycle.
REQ-033 rst asserted in WAIT of row 1 -> next cycle busy=0, all vector_out=0000, row_idx=0, dot_start=0.
REQ-034 With HALF_DOT_SCHED_TIMEOUT_EN, TIMEOUT=8, engine never answers row 0 -> timeout=1 and done pulse after 8 WAIT cycles; next start clears timeout.
REQ-035 Spurious dot_done in IDLE and ISSUE -> no vector_out change, state sequence unchanged.
